// File: rtl/rv32i_types.sv
// Shared RV32I types: base opcodes, immediate formats and opcode helpers.
// Used by the instruction buffer and its decoder.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        fmt_i,
        fmt_s,
        fmt_b,
        fmt_u,
        fmt_j,
        fmt_none
    } imm_fmt_t;

    function automatic imm_fmt_t fmt_of(logic [6:0] op);
        imm_fmt_t f;
        case (op)
            op_lui, op_auipc:        f = fmt_u;
            op_jal:                  f = fmt_j;
            op_jalr, op_load, op_imm: f = fmt_i;
            op_store:                f = fmt_s;
            op_br:                   f = fmt_b;
            default:                 f = fmt_none;
        endcase
        return f;
    endfunction

    function automatic logic is_legal(logic [6:0] op);
        logic l;
        case (op)
            op_lui, op_auipc, op_jal, op_jalr, op_br,
            op_load, op_store, op_imm, op_reg, op_csr: l = 1'b1;
            default:                                   l = 1'b0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// Producer/consumer bundle of the instruction buffer.
// The buffer takes the slave side; the fetch/decode environment the master side.
interface inst_buffer_if
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              flush;
    logic              enq_valid;
    logic              enq_ready;
    logic [31:0]       enq_inst;
    logic [31:0]       enq_pc;
    logic              deq_valid;
    logic              deq_ready;
    logic [31:0]       inst;
    logic [31:0]       pc;
    rv32i_opcode       opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       imm;
    logic              illegal;
    logic [CW-1:0]     count;

    modport master (
        output flush, enq_valid, enq_inst, enq_pc, deq_ready,
        input  enq_ready, deq_valid, inst, pc, opcode, funct3, funct7,
               rs1, rs2, rd, imm, illegal, count
    );

    modport slave (
        input  flush, enq_valid, enq_inst, enq_pc, deq_ready,
        output enq_ready, deq_valid, inst, pc, opcode, funct3, funct7,
               rs1, rs2, rd, imm, illegal, count
    );

endinterface

// File: rtl/inst_decode.sv
// Combinational RV32I field extraction, immediate generation and
// illegal-opcode detection for one 32-bit instruction word.
module inst_decode
    import rv32i_types::*;
(
    input  logic [31:0] word,
    output rv32i_opcode opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        illegal
);
    imm_fmt_t fmt;

    assign opcode  = rv32i_opcode'(word[6:0]);
    assign funct3  = word[14:12];
    assign funct7  = word[31:25];
    assign rs1     = word[19:15];
    assign rs2     = word[24:20];
    assign rd      = word[11:7];
    assign illegal = !is_legal(word[6:0]);
    assign fmt     = fmt_of(word[6:0]);

    always_comb begin
        imm = '0;
        case (fmt)
            fmt_i: imm = {{20{word[31]}}, word[31:20]};
            fmt_s: imm = {{20{word[31]}}, word[31:25], word[11:7]};
            fmt_b: imm = {{19{word[31]}}, word[31], word[7],
                          word[30:25], word[11:8], 1'b0};
            fmt_u: imm = {word[31:12], 12'h000};
            fmt_j: imm = {{11{word[31]}}, word[31], word[19:12],
                          word[20], word[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction FIFO between fetch and decode; the head entry is
// presented already decoded, with no enqueue-to-head bypass.
module inst_buffer
    import rv32i_types::*;
#(
    parameter int DEPTH           = 4,
    parameter bit ZERO_WHEN_EMPTY = 1'b1
)(
    input  logic         clk,
    input  logic         rst,
    inst_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          enq_fire;
    logic          deq_fire;

    assign full     = (cnt == FULL);
    assign empty    = (cnt == '0);
    assign enq_fire = bus.enq_valid && !full;
    assign deq_fire = bus.deq_ready && !empty;

    assign bus.enq_ready = !full;
    assign bus.deq_valid = !empty;
    assign bus.count     = cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
            if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
            case ({enq_fire, deq_fire})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage carries no reset.
    always_ff @(posedge clk) begin
        if (enq_fire && !rst && !bus.flush) begin
            inst_mem[wr_ptr] <= bus.enq_inst;
            pc_mem[wr_ptr]   <= bus.enq_pc;
        end
    end

    logic [31:0] head_inst;
    logic [31:0] head_pc;
    rv32i_opcode d_opcode;
    logic [2:0]  d_funct3;
    logic [6:0]  d_funct7;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [4:0]  d_rd;
    logic [31:0] d_imm;
    logic        d_illegal;

    assign head_inst = inst_mem[rd_ptr];
    assign head_pc   = pc_mem[rd_ptr];

    inst_decode dec (
        .word    (head_inst),
        .opcode  (d_opcode),
        .funct3  (d_funct3),
        .funct7  (d_funct7),
        .rs1     (d_rs1),
        .rs2     (d_rs2),
        .rd      (d_rd),
        .imm     (d_imm),
        .illegal (d_illegal)
    );

    always_comb begin
        bus.inst    = head_inst;
        bus.pc      = head_pc;
        bus.opcode  = d_opcode;
        bus.funct3  = d_funct3;
        bus.funct7  = d_funct7;
        bus.rs1     = d_rs1;
        bus.rs2     = d_rs2;
        bus.rd      = d_rd;
        bus.imm     = d_imm;
        bus.illegal = d_illegal && !empty;
        if (ZERO_WHEN_EMPTY && empty) begin
            bus.inst    = '0;
            bus.pc      = '0;
            bus.opcode  = rv32i_opcode'(7'h00);
            bus.funct3  = '0;
            bus.funct7  = '0;
            bus.rs1     = '0;
            bus.rs2     = '0;
            bus.rd      = '0;
            bus.imm     = '0;
            bus.illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: directed scenarios plus a randomized
// run compared against a queue-based model of the buffer.
module tb_inst_buffer;
    import rv32i_types::*;

    localparam int D = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [63:0] mq[$];

    inst_buffer_if #(.DEPTH(D)) bus ();

    inst_buffer #(.DEPTH(D), .ZERO_WHEN_EMPTY(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_imm(logic [31:0] w);
        logic [31:0] v;
        case (w & 32'h7f)
            32'h37, 32'h17: v = w & 32'hFFFF_F000;
            32'h6f: begin
                v = (((w >> 21) & 32'h3ff) << 1) | (((w >> 20) & 1) << 11)
                  | (((w >> 12) & 32'hff) << 12) | ((w >> 31) << 20);
                if (w[31]) v = v - 32'h0020_0000;
            end
            32'h67, 32'h03, 32'h13: begin
                v = w >> 20;
                if (w[31]) v = v - 32'd4096;
            end
            32'h23: begin
                v = ((w >> 25) << 5) | ((w >> 7) & 32'h1f);
                if (w[31]) v = v - 32'd4096;
            end
            32'h63: begin
                v = (((w >> 8) & 32'hf) << 1) | (((w >> 25) & 32'h3f) << 5)
                  | (((w >> 7) & 1) << 11) | ((w >> 31) << 12);
                if (w[31]) v = v - 32'd8192;
            end
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    function automatic bit ref_legal(logic [31:0] w);
        logic [6:0] ops [10];
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        foreach (ops[k]) if (w[6:0] == ops[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_in(bit ev, logic [31:0] w, logic [31:0] p, bit dr, bit fl);
        bus.enq_valid = ev;
        bus.enq_inst  = w;
        bus.enq_pc    = p;
        bus.deq_ready = dr;
        bus.flush     = fl;
    endtask

    task automatic tick();
        bit ef;
        bit df;
        ef = bus.enq_valid && (mq.size() < D);
        df = bus.deq_ready && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (rst || bus.flush) begin
            mq.delete();
        end else begin
            if (df) void'(mq.pop_front());
            if (ef) mq.push_back({bus.enq_inst, bus.enq_pc});
        end
    endtask

    task automatic test_reset();
        set_in(0, 32'h0, 32'h0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.count !== 3'd0 || bus.deq_valid !== 1'b0 || bus.enq_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_flags got cnt=%0d dv=%b er=%b want 0 0 1",
                     bus.count, bus.deq_valid, bus.enq_ready);
        end
        checks++;
        if (bus.inst !== 32'h0 || bus.imm !== 32'h0 || bus.illegal !== 1'b0
            || bus.opcode !== 7'h0 || bus.pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_head got inst=%h imm=%h ill=%b want zeros",
                     bus.inst, bus.imm, bus.illegal);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        set_in(1, 32'h0050_0093, 32'h40, 0, 0);
        #1;
        checks++;
        if (bus.deq_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_bypass got dv=%b want 0", bus.deq_valid);
        end
        tick();
        set_in(0, 32'h0, 32'h0, 0, 0);
        checks++;
        if (bus.deq_valid !== 1'b1 || bus.opcode !== 7'h13 || bus.rd !== 5'd1
            || bus.rs1 !== 5'd0 || bus.imm !== 32'd5 || bus.pc !== 32'h40) begin
            failures++;
            $display("FAIL single got dv=%b op=%h rd=%0d rs1=%0d imm=%h pc=%h want 1 13 1 0 5 40",
                     bus.deq_valid, bus.opcode, bus.rd, bus.rs1, bus.imm, bus.pc);
        end
        set_in(0, 32'h0, 32'h0, 1, 0);
        tick();
        checks++;
        if (bus.count !== 3'd0) begin
            failures++;
            $display("FAIL single_drain got cnt=%0d want 0", bus.count);
        end
    endtask

    task automatic test_full();
        logic [31:0] words [4];
        words = '{32'h0010_0113, 32'h0020_8193, 32'h0031_0233, 32'h0041_82B3};
        for (int i = 0; i < 4; i++) begin
            set_in(1, words[i], 32'h100 + 32'(i * 4), 0, 0);
            tick();
        end
        checks++;
        if (bus.count !== 3'd4 || bus.enq_ready !== 1'b0) begin
            failures++;
            $display("FAIL full got cnt=%0d er=%b want 4 0", bus.count, bus.enq_ready);
        end
        set_in(1, 32'hDEAD_0013, 32'h200, 0, 0);
        tick();
        checks++;
        if (bus.count !== 3'd4 || bus.inst !== words[0]) begin
            failures++;
            $display("FAIL fifth_ignored got cnt=%0d inst=%h want 4 %h",
                     bus.count, bus.inst, words[0]);
        end
        set_in(1, 32'hBEEF_0013, 32'h204, 1, 0);
        tick();
        checks++;
        if (bus.count !== 3'd3 || bus.inst !== words[1]) begin
            failures++;
            $display("FAIL full_enq_deq got cnt=%0d inst=%h want 3 %h",
                     bus.count, bus.inst, words[1]);
        end
        set_in(0, 32'h0, 32'h0, 1, 0);
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (bus.inst !== words[i] || bus.pc !== 32'h100 + 32'(i * 4)) begin
                failures++;
                $display("FAIL order[%0d] got inst=%h pc=%h want %h %h", i,
                         bus.inst, bus.pc, words[i], 32'h100 + 32'(i * 4));
            end
            tick();
        end
        checks++;
        if (bus.count !== 3'd0 || bus.deq_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_drain got cnt=%0d dv=%b want 0 0", bus.count, bus.deq_valid);
        end
    endtask

    task automatic test_imm();
        logic [31:0] words [3];
        logic [31:0] exp [3];
        words = '{32'hFE00_0EE3, 32'hFE11_2E23, 32'h1234_50B7};
        exp   = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h1234_5000};
        for (int i = 0; i < 3; i++) begin
            set_in(1, words[i], 32'h300 + 32'(i * 4), 0, 0);
            tick();
        end
        set_in(0, 32'h0, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.imm !== exp[i] || bus.illegal !== 1'b0) begin
                failures++;
                $display("FAIL imm[%0d] got imm=%h ill=%b want %h 0", i,
                         bus.imm, bus.illegal, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'h00A0_0513 + 32'(i), 32'h400 + 32'(i * 4), 0, 0);
            tick();
        end
        checks++;
        if (bus.count !== 3'd3) begin
            failures++;
            $display("FAIL flush_pre got cnt=%0d want 3", bus.count);
        end
        set_in(1, 32'h0FF0_0593, 32'h40C, 1, 1);
        tick();
        set_in(0, 32'h0, 32'h0, 0, 0);
        checks++;
        if (bus.count !== 3'd0 || bus.deq_valid !== 1'b0 || bus.enq_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_flags got cnt=%0d dv=%b er=%b want 0 0 1",
                     bus.count, bus.deq_valid, bus.enq_ready);
        end
        checks++;
        if (bus.inst !== 0 || bus.pc !== 0 || bus.imm !== 0 || bus.rd !== 0
            || bus.rs1 !== 0 || bus.rs2 !== 0 || bus.funct3 !== 0
            || bus.funct7 !== 0 || bus.opcode !== 7'h0 || bus.illegal !== 0) begin
            failures++;
            $display("FAIL flush_head got inst=%h pc=%h imm=%h want zeros",
                     bus.inst, bus.pc, bus.imm);
        end
    endtask

    task automatic test_illegal_reset();
        set_in(1, 32'hFFFF_FFFF, 32'h500, 0, 0);
        tick();
        checks++;
        if (bus.illegal !== 1'b1 || bus.imm !== 32'h0) begin
            failures++;
            $display("FAIL illegal got ill=%b imm=%h want 1 0", bus.illegal, bus.imm);
        end
        set_in(1, 32'h0010_0093, 32'h504, 0, 0);
        tick();
        set_in(1, 32'h0020_0093, 32'h508, 1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(0, 32'h0, 32'h0, 0, 0);
        checks++;
        if (bus.count !== 3'd0 || bus.illegal !== 1'b0 || bus.deq_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got cnt=%0d ill=%b dv=%b want 0 0 0",
                     bus.count, bus.illegal, bus.deq_valid);
        end
        set_in(1, 32'h0050_0093, 32'h80, 0, 0);
        tick();
        set_in(0, 32'h0, 32'h0, 0, 0);
        checks++;
        if (bus.inst !== 32'h0050_0093 || bus.pc !== 32'h80 || bus.count !== 3'd1) begin
            failures++;
            $display("FAIL post_reset got inst=%h pc=%h cnt=%0d want 00500093 80 1",
                     bus.inst, bus.pc, bus.count);
        end
        set_in(0, 32'h0, 32'h0, 1, 0);
        tick();
    endtask

    task automatic test_random();
        logic [6:0]  ops [10];
        logic [31:0] w;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [31:0] e_imm;
        bit          e_ill;
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        for (int n = 0; n < 400; n++) begin
            w = $urandom();
            if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 9)];
            set_in($urandom_range(0, 2) != 0, w, $urandom() & 32'hFFFF_FFFC,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 30) == 0);
            rst = ($urandom_range(0, 60) == 0);
            tick();
            rst = 1'b0;
            set_in(0, 32'h0, 32'h0, 0, 0);
            checks++;
            if (bus.count !== 3'(mq.size()) || bus.deq_valid !== (mq.size() != 0)
                || bus.enq_ready !== (mq.size() != D)) begin
                failures++;
                $display("FAIL rnd_flags[%0d] got cnt=%0d dv=%b er=%b want cnt=%0d",
                         n, bus.count, bus.deq_valid, bus.enq_ready, mq.size());
            end
            e_inst = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
            e_pc   = (mq.size() != 0) ? mq[0][31:0] : 32'h0;
            e_imm  = ref_imm(e_inst);
            e_ill  = (mq.size() != 0) && !ref_legal(e_inst);
            checks++;
            if (bus.inst !== e_inst || bus.pc !== e_pc || bus.imm !== e_imm
                || bus.illegal !== e_ill) begin
                failures++;
                $display("FAIL rnd_head[%0d] got inst=%h pc=%h imm=%h ill=%b want %h %h %h %b",
                         n, bus.inst, bus.pc, bus.imm, bus.illegal,
                         e_inst, e_pc, e_imm, e_ill);
            end
            checks++;
            if (bus.opcode !== (e_inst & 32'h7f) || bus.rd !== ((e_inst >> 7) & 32'h1f)
                || bus.rs1 !== ((e_inst >> 15) & 32'h1f)
                || bus.rs2 !== ((e_inst >> 20) & 32'h1f)
                || bus.funct3 !== ((e_inst >> 12) & 32'h7)
                || bus.funct7 !== (e_inst >> 25)) begin
                failures++;
                $display("FAIL rnd_fields[%0d] got op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h for %h",
                         n, bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3,
                         bus.funct7, e_inst);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        set_in(0, 32'h0, 32'h0, 0, 0);
        test_reset();
        test_single();
        test_full();
        test_imm();
        test_flush();
        test_illegal_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
